arbiter_merge2: RTL and testbench

ARBITER_MERGE2 -- requirements
Module: arbiter_merge2

---
 rtl/arbiter_merge2.sv | 145 ++++++++++++++
 tb/tb_arbiter_merge2.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/arbiter_merge2.sv
// rtl/arbiter_merge2.sv - two-input packet merge with 2-entry output buffer; optional ARB_ROUND_ROBIN_EN selects round-robin tie-break
module arbiter_merge2 #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sel
);

  // Buffer capacity as a count value; pointers are one bit and wrap modulo 2 on their own.
  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         rd_ptr;
  logic         rd_ptr_next;
  logic         wr_ptr;
  logic         wr_ptr_next;
  logic [W-1:0] mem_data [DEPTH];
  logic         mem_sel  [DEPTH];

  logic         space;
  logic         grant0;
  logic         grant1;
  logic         push;
  logic         pop;
  logic [W-1:0] push_data;
  logic         push_sel;
  logic [W-1:0] head_data_next;
  logic         head_sel_next;

`ifdef ARB_ROUND_ROBIN_EN
  // High when in1 won the most recent transfer, so in0 gets the next tie.
  logic         last_grant;
`endif

  // Space depends on the registered count only, never on out_ready.
  assign space = (count < FULL);

  // Pick at most one input: the sole valid one, or the tie-break winner when both are valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (in0_valid && in1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_grant) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
`else
      grant0 = 1'b1;
`endif
    end else if (in0_valid) begin
      grant0 = 1'b1;
    end else if (in1_valid) begin
      grant1 = 1'b1;
    end
  end

  // Handshake signals; reset forces every ready/valid low regardless of stored state.
  assign in0_ready = _RESET && space && grant0;
  assign in1_ready = _RESET && space && grant1;
  assign out_valid = _RESET && (count != 2'd0);

  assign push      = in0_ready || in1_ready;
  assign pop       = out_valid && out_ready;
  assign push_data = grant1 ? in1_data : in0_data;
  assign push_sel  = grant1;

  // Next count and pointers; a simultaneous push and pop leaves count alone and moves both pointers.
  always_comb begin
    count_next  = count;
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    if (push) begin
      wr_ptr_next = ~wr_ptr;
    end
    if (pop) begin
      rd_ptr_next = ~rd_ptr;
    end
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Head of the buffer after this edge: the entry being written if it lands at the new read slot, else the stored entry.
  always_comb begin
    head_data_next = mem_data[rd_ptr_next];
    head_sel_next  = mem_sel[rd_ptr_next];
    if (push && (wr_ptr == rd_ptr_next)) begin
      head_data_next = push_data;
      head_sel_next  = push_sel;
    end
  end

  // Buffer storage, occupancy, pointers and registered head outputs.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      out_data <= '0;
      out_sel  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_sel[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_sel[wr_ptr]  <= push_sel;
      end
      count    <= count_next;
      rd_ptr   <= rd_ptr_next;
      wr_ptr   <= wr_ptr_next;
      out_data <= head_data_next;
      out_sel  <= head_sel_next;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the winner, but only in cycles where a packet was actually taken.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      last_grant <= 1'b1;
    end else if (push) begin
      last_grant <= grant1;
    end
  end
`endif

endmodule

// File: tb/tb_arbiter_merge2.sv
// tb/tb_arbiter_merge2.sv - randomized scoreboard bench for arbiter_merge2 (honours ARB_ROUND_ROBIN_EN)
module tb_arbiter_merge2;

  localparam int W = 9;

  typedef struct packed {
    logic         sel;
    logic [W-1:0] data;
  } pkt_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in0_data = '0;
  logic         in0_valid = 1'b0;
  logic         in0_ready;
  logic [W-1:0] in1_data = '0;
  logic         in1_valid = 1'b0;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_sel;

  // Reference state: packets accepted and not yet delivered, and who won the last transfer.
  pkt_t exp_q[$];
  logic model_in1_last = 1'b1;
  bit   prev_rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  arbiter_merge2 #(.W(W), .DEPTH(2)) dut (
    .CLK       (clk),
    ._RESET    (rst_n),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // One clock of stimulus: drive at negedge, compare readies against the arbitration rules, record accepted packet.
  task automatic cycle(input bit rst, input bit v0, input logic [W-1:0] d0,
                       input bit v1, input logic [W-1:0] d1, input bit ordy);
    bit e0;
    bit e1;
    @(negedge clk);
    rst_n     = !rst;
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && exp_q.size() < 2) begin
      if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
        e0 = model_in1_last;
        e1 = !model_in1_last;
`else
        e0 = 1'b1;
`endif
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    check("in0_ready", 32'(in0_ready), 32'(e0));
    check("in1_ready", 32'(in1_ready), 32'(e1));
    if (prev_rst && !rst) begin
      check("out_data_after_reset", 32'(out_data), 32'd0);
      check("out_sel_after_reset", 32'(out_sel), 32'd0);
    end
    prev_rst = rst;
    #2;
    if (rst) begin
      exp_q.delete();
      model_in1_last = 1'b1;
    end else if (e0) begin
      exp_q.push_back({1'b0, d0});
      model_in1_last = 1'b0;
    end else if (e1) begin
      exp_q.push_back({1'b1, d1});
      model_in1_last = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    end
  endtask

  // Monitor: compare the presented head against the oldest expected packet, retire it on handshake.
  initial begin
    pkt_t h;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("out_valid_in_reset", 32'(out_valid), 32'd0);
      end else begin
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          check("out_data", 32'(out_data), 32'(h.data));
          check("out_sel", 32'(out_sel), 32'(h.sel));
          if (out_ready) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Stimulus: reset, directed scenarios, then randomized phases with varied valid/ready densities.
  initial begin
    int pv;
    int pr;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 9'h0AA, 1'b1, 9'h155, 1'b1);
    end

    cycle(1'b0, 1'b1, 9'h1A5, 1'b0, '0, 1'b1);
    idle(3);

    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, W'(9'h100 + i), 1'b1, W'(9'h0E0 + i), 1'b1);
    end
    idle(3);

    cycle(1'b0, 1'b0, '0, 1'b1, 9'h050, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 9'h051, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 9'h052, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 9'h052, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 9'h052, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 9'h052, 1'b1);
    idle(3);

    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, W'(9'h010 + i), 1'b0, '0, 1'b1);
    end
    idle(3);

    cycle(1'b0, 1'b1, 9'h0A1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 9'h0A2, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 9'h0A3, 1'b1, 9'h0A4, 1'b1);
    cycle(1'b0, 1'b1, 9'h0FF, 1'b0, '0, 1'b1);
    idle(3);

    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pv = 50;  pr = 90;  end
        1:       begin pv = 80;  pr = 30;  end
        2:       begin pv = 100; pr = 100; end
        default: begin pv = 40;  pr = 60;  end
      endcase
      for (int i = 0; i < 250; i++) begin
        cycle(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < pv), W'($urandom),
              ($urandom_range(0, 99) < pv), W'($urandom),
              ($urandom_range(0, 99) < pr));
      end
    end
    idle(4);

    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
